// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/memory arbiter: default widths, FSM state
// encoding, requester identifiers and the two-way round-robin pick function.
package cache_mem_arbiter_pkg;

    localparam int unsigned BLOCK_ADDR_W_DEF = 9;
    localparam int unsigned LINE_W_DEF       = 256;
    localparam int unsigned TIMEOUT_DEF      = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    // Two-way round robin: a lone requester always wins; on a tie the side
    // that did not win last time is chosen. Caller qualifies with "any active".
    function automatic req_id_e rr_pick(input logic    ic_act,
                                        input logic    dc_act,
                                        input req_id_e last);
        req_id_e pick;
        if (ic_act && dc_act) begin
            pick = (last == REQ_IC) ? REQ_DC : REQ_IC;
        end else if (dc_act) begin
            pick = REQ_DC;
        end else begin
            pick = REQ_IC;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a last-grant register.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   ic_act       - instruction side has a request pending
//   dc_act       - data side has a request pending
//   take         - the current grant is being accepted this cycle
//   gnt_valid_c  - combinational: some requester is pending
//   gnt_id_c     - combinational: requester that wins this cycle
module cache_mem_arbiter_rr_arbiter2
    import cache_mem_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    ic_act,
    input  logic    dc_act,
    input  logic    take,
    output logic    gnt_valid_c,
    output req_id_e gnt_id_c
);

    req_id_e last_q;
    req_id_e last_d;

    // Grant decision; history only moves when the grant is actually taken.
    always_comb begin
        gnt_valid_c = ic_act | dc_act;
        gnt_id_c    = rr_pick(ic_act, dc_act, last_q);
        last_d      = last_q;
        if (take && gnt_valid_c) begin
            last_d = gnt_id_c;
        end
    end

    // Reset to instruction so the data side wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_IC;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates instruction-cache line reads and data-cache line reads/writebacks
// onto a single main-memory port, one transaction in flight at a time.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   ic_req, ic_block_addr           - instruction line read request (level)
//   ic_line, ic_ready               - returned line, one-cycle completion pulse
//   dc_rd_req, dc_wr_req            - data read / writeback requests (level)
//   dc_block_addr, dc_wr_line       - data address and writeback line
//   dc_line, dc_ready               - returned line, one-cycle completion pulse
//   data_cache_busy                 - combinational: data side pending or granted
//   mem_block_addr, mem_rd, mem_wr  - memory address and strobes (held to ack)
//   mem_wdata, mem_rdata, mem_ack   - memory data and completion
//   mem_err                         - sticky memory timeout flag
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned BLOCK_ADDR_W = BLOCK_ADDR_W_DEF,
    parameter int unsigned LINE_W       = LINE_W_DEF,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ic_req,
    input  logic [BLOCK_ADDR_W-1:0] ic_block_addr,
    output logic [LINE_W-1:0]       ic_line,
    output logic                    ic_ready,
    input  logic                    dc_rd_req,
    input  logic                    dc_wr_req,
    input  logic [BLOCK_ADDR_W-1:0] dc_block_addr,
    input  logic [LINE_W-1:0]       dc_wr_line,
    output logic [LINE_W-1:0]       dc_line,
    output logic                    dc_ready,
    output logic                    data_cache_busy,
    output logic [BLOCK_ADDR_W-1:0] mem_block_addr,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [LINE_W-1:0]       mem_wdata,
    input  logic [LINE_W-1:0]       mem_rdata,
    input  logic                    mem_ack,
    output logic                    mem_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e                  state_q,    state_d;
    req_id_e                 gnt_q,      gnt_d;
    logic                    is_wr_q,    is_wr_d;
    logic [BLOCK_ADDR_W-1:0] addr_q,     addr_d;
    logic [LINE_W-1:0]       wdata_q,    wdata_d;
    logic                    mem_rd_q,   mem_rd_d;
    logic                    mem_wr_q,   mem_wr_d;
    logic                    ic_ready_q, ic_ready_d;
    logic                    dc_ready_q, dc_ready_d;
    logic [LINE_W-1:0]       ic_line_q,  ic_line_d;
    logic [LINE_W-1:0]       dc_line_q,  dc_line_d;
    logic                    mem_err_q,  mem_err_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;

    logic                    arb_valid_c;
    req_id_e                 arb_gnt_c;
    logic                    arb_take;
    logic                    resp_done;
    logic [LINE_W-1:0]       resp_line;

    // A data-side request is "pending" when either of its strobes is up.
    cache_mem_arbiter_rr_arbiter2 u_rr (
        .clk         (clk),
        .reset       (reset),
        .ic_act      (ic_req),
        .dc_act      (dc_rd_req | dc_wr_req),
        .take        (arb_take),
        .gnt_valid_c (arb_valid_c),
        .gnt_id_c    (arb_gnt_c)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        ic_ready_d = 1'b0;
        dc_ready_d = 1'b0;
        ic_line_d  = ic_line_q;
        dc_line_d  = dc_line_q;
        mem_err_d  = mem_err_q;
        cnt_d      = cnt_q;
        arb_take   = 1'b0;
        resp_done  = 1'b0;
        resp_line  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid_c) begin
                    arb_take = 1'b1;
                    gnt_d    = arb_gnt_c;
                    // Data side with both strobes up does the writeback first.
                    if (arb_gnt_c == REQ_DC) begin
                        is_wr_d = dc_wr_req;
                        addr_d  = dc_block_addr;
                        wdata_d = dc_wr_line;
                    end else begin
                        is_wr_d = 1'b0;
                        addr_d  = ic_block_addr;
                    end
                    mem_rd_d = ~is_wr_d;
                    mem_wr_d = is_wr_d;
                    cnt_d    = '0;
                    state_d  = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (mem_ack) begin
                    resp_done = 1'b1;
                    resp_line = mem_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Give up: requester gets an all-zero line and the error sticks.
                    resp_done = 1'b1;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (resp_done) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = ST_RESPOND;
                    if (gnt_q == REQ_DC) begin
                        dc_ready_d = 1'b1;
                        // A completed writeback returns no line; a timed-out one returns zero.
                        if (!is_wr_q || !mem_ack) begin
                            dc_line_d = resp_line;
                        end
                    end else begin
                        ic_ready_d = 1'b1;
                        ic_line_d  = resp_line;
                    end
                end
            end

            ST_RESPOND: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= REQ_IC;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            ic_ready_q <= 1'b0;
            dc_ready_q <= 1'b0;
            ic_line_q  <= '0;
            dc_line_q  <= '0;
            mem_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            ic_ready_q <= ic_ready_d;
            dc_ready_q <= dc_ready_d;
            ic_line_q  <= ic_line_d;
            dc_line_q  <= dc_line_d;
            mem_err_q  <= mem_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ic_line        = ic_line_q;
    assign ic_ready       = ic_ready_q;
    assign dc_line        = dc_line_q;
    assign dc_ready       = dc_ready_q;
    assign mem_block_addr = addr_q;
    assign mem_rd         = mem_rd_q;
    assign mem_wr         = mem_wr_q;
    assign mem_wdata      = wdata_q;
    assign mem_err        = mem_err_q;

    // Follows the request lines directly so the data cache sees busy immediately.
    assign data_cache_busy = dc_rd_req | dc_wr_req |
                             ((state_q != ST_IDLE) && (gnt_q == REQ_DC));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: requester and memory models plus a
// scoreboard of expected memory transactions and completions.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

    localparam int unsigned AW  = 9;
    localparam int unsigned LW  = 256;
    localparam int unsigned TMO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req;
    logic [AW-1:0] ic_block_addr;
    logic [LW-1:0] ic_line;
    logic          ic_ready;
    logic          dc_rd_req;
    logic          dc_wr_req;
    logic [AW-1:0] dc_block_addr;
    logic [LW-1:0] dc_wr_line;
    logic [LW-1:0] dc_line;
    logic          dc_ready;
    logic          data_cache_busy;
    logic [AW-1:0] mem_block_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_err;

    cache_mem_arbiter #(.BLOCK_ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .ic_req          (ic_req),
        .ic_block_addr   (ic_block_addr),
        .ic_line         (ic_line),
        .ic_ready        (ic_ready),
        .dc_rd_req       (dc_rd_req),
        .dc_wr_req       (dc_wr_req),
        .dc_block_addr   (dc_block_addr),
        .dc_wr_line      (dc_wr_line),
        .dc_line         (dc_line),
        .dc_ready        (dc_ready),
        .data_cache_busy (data_cache_busy),
        .mem_block_addr  (mem_block_addr),
        .mem_rd          (mem_rd),
        .mem_wr          (mem_wr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          who;   // 0 instruction, 1 data
        logic          wr;
        logic          tmo;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] line;
    } txn_t;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
    } dreq_t;

    txn_t          exp_q[$];
    txn_t          cur;
    logic          cur_valid;
    logic [AW-1:0] ic_pend[$];
    dreq_t         dc_pend[$];

    int n_checks;
    int n_fail;
    int ncyc;
    int ack_delay;
    int wait_cnt;
    int strobe_cycles;
    int ready_cyc;
    int ready_seen;

    function automatic logic [LW-1:0] mk_line(input logic [AW-1:0] a, input logic [7:0] salt);
        logic [31:0] w;
        w = {7'h55, a, 8'hC3, salt};
        return {8{w}};
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void push_exp(input logic who, input logic wr, input logic tmo,
                                     input logic [AW-1:0] a);
        txn_t t;
        t.who   = who;
        t.wr    = wr;
        t.tmo   = tmo;
        t.addr  = a;
        t.wdata = wr ? mk_line(a, 8'hEE) : '0;
        t.line  = (tmo || wr) ? '0 : mk_line(a, 8'h11);
        exp_q.push_back(t);
    endfunction

    function automatic void push_dc(input logic wr, input logic rd, input logic [AW-1:0] a);
        dreq_t d;
        d.wr   = wr;
        d.rd   = rd;
        d.addr = a;
        dc_pend.push_back(d);
    endfunction

    // Requester models present the head of their pending queues.
    task automatic drive_reqs();
        if (ic_pend.size() > 0) begin
            ic_req        = 1'b1;
            ic_block_addr = ic_pend[0];
        end else begin
            ic_req        = 1'b0;
            ic_block_addr = '0;
        end
        if (dc_pend.size() > 0) begin
            dc_wr_req     = dc_pend[0].wr;
            dc_rd_req     = dc_pend[0].rd;
            dc_block_addr = dc_pend[0].addr;
            dc_wr_line    = mk_line(dc_pend[0].addr, 8'hEE);
        end else begin
            dc_wr_req     = 1'b0;
            dc_rd_req     = 1'b0;
            dc_block_addr = '0;
            dc_wr_line    = '0;
        end
    endtask

    // One clock: observe completions, run the memory model, update requesters.
    task automatic tick();
        dreq_t d;
        @(posedge clk);
        #1;
        ncyc++;
        mem_ack = 1'b0;

        if (ic_ready || dc_ready) begin
            ready_cyc = ncyc;
            ready_seen++;
            check("ready_onehot", ic_ready & dc_ready, 1'b0);
            check("ready_expected", cur_valid, 1'b1);
            if (cur_valid) begin
                check("ready_who", dc_ready, cur.who);
                if (cur.tmo) begin
                    check("tmo_err", mem_err, 1'b1);
                    check("tmo_wait_cycles", strobe_cycles, TMO);
                end
                if (!cur.wr || cur.tmo) begin
                    check(cur.who ? "dc_line" : "ic_line", cur.who ? dc_line : ic_line, cur.line);
                end
                if (cur.who) begin
                    if (dc_pend.size() > 0) begin
                        d = dc_pend[0];
                        if (d.wr) d.wr = 1'b0;
                        else      d.rd = 1'b0;
                        if (!d.wr && !d.rd) dc_pend.delete(0);
                        else                dc_pend[0] = d;
                    end
                end else if (ic_pend.size() > 0) begin
                    ic_pend.delete(0);
                end
                cur_valid = 1'b0;
            end
            drive_reqs();
        end

        if (mem_rd || mem_wr) begin
            if (!cur_valid) begin
                check("txn_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    cur           = exp_q.pop_front();
                    cur_valid     = 1'b1;
                    wait_cnt      = 0;
                    strobe_cycles = 0;
                end
            end
            if (cur_valid) begin
                strobe_cycles++;
                wait_cnt++;
                check("mem_wr", mem_wr, cur.wr);
                check("mem_rd", mem_rd, !cur.wr);
                check("mem_addr", mem_block_addr, cur.addr);
                if (cur.wr) check("mem_wdata", mem_wdata, cur.wdata);
                if (!cur.tmo && wait_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur.wr ? mk_line(cur.addr, 8'h77) : cur.line;
                end
            end
        end
    endtask

    // Clock until every expected transaction has completed, then one idle cycle.
    task automatic run(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || cur_valid) && n < budget) begin
            tick();
            n++;
        end
        check("run_done", (exp_q.size() == 0) && !cur_valid, 1'b1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int seen0;

        n_checks = 0; n_fail = 0; ncyc = 0; ready_seen = 0; ready_cyc = 0;
        wait_cnt = 0; strobe_cycles = 0; cur_valid = 1'b0; ack_delay = 1;
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        drive_reqs();

        // Reset state
        repeat (2) tick();
        check("rst_ic_ready", ic_ready, 1'b0);
        check("rst_dc_ready", dc_ready, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_err", mem_err, 1'b0);
        check("rst_ic_line", ic_line, '0);
        check("rst_dc_line", dc_line, '0);
        check("rst_busy", data_cache_busy, 1'b0);
        reset = 1'b0;
        tick();

        // Simultaneous first requests: data wins the first tie, then instruction
        ack_delay = 2;
        push_exp(1'b1, 1'b0, 1'b0, 9'h020);
        push_exp(1'b0, 1'b0, 1'b0, 9'h010);
        ic_pend.push_back(9'h010);
        push_dc(1'b0, 1'b1, 9'h020);
        drive_reqs();
        #1 check("busy_on_req", data_cache_busy, 1'b1);
        run(50);
        check("busy_idle", data_cache_busy, 1'b0);

        // Instruction-only read, ack after three strobe cycles
        ack_delay = 3;
        seen0 = ready_seen;
        push_exp(1'b0, 1'b0, 1'b0, 9'h03A);
        ic_pend.push_back(9'h03A);
        drive_reqs();
        run(50);
        check("ic_ready_once", ready_seen - seen0, 1);

        // Minimum latency: request cycle N, ready cycle N+2
        ack_delay = 1;
        start = ncyc;
        push_exp(1'b1, 1'b0, 1'b0, 9'h055);
        push_dc(1'b0, 1'b1, 9'h055);
        drive_reqs();
        run(50);
        check("min_latency", ready_cyc - start, 2);

        // Writeback and read together: write first, then read
        ack_delay = 2;
        push_exp(1'b1, 1'b1, 1'b0, 9'h101);
        push_exp(1'b1, 1'b0, 1'b0, 9'h101);
        push_dc(1'b1, 1'b1, 9'h101);
        drive_reqs();
        run(60);

        // Both sides continuously pending: last grant was data, so alternate from instruction
        ack_delay = 2;
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 1'b0, 1'b0, 9'h0C0 + 9'(i));
            push_exp(1'b1, 1'b0, 1'b0, 9'h1C0 + 9'(i));
            ic_pend.push_back(9'h0C0 + 9'(i));
            push_dc(1'b0, 1'b1, 9'h1C0 + 9'(i));
        end
        drive_reqs();
        run(200);

        // Stray ack while idle is ignored and returned lines hold
        seen0 = ready_seen;
        mem_rdata = mk_line(9'h1FF, 8'h99);
        mem_ack = 1'b1;
        tick();
        check("stray_ack_strobe", mem_rd | mem_wr, 1'b0);
        tick();
        check("stray_ack_ready", ready_seen - seen0, 0);
        check("hold_ic_line", ic_line, mk_line(9'h0C3, 8'h11));
        check("hold_dc_line", dc_line, mk_line(9'h1C3, 8'h11));

        // No ack: timeout, zero line, sticky error
        push_exp(1'b0, 1'b0, 1'b1, 9'h0F0);
        ic_pend.push_back(9'h0F0);
        drive_reqs();
        run(200);
        check("err_set", mem_err, 1'b1);
        ack_delay = 1;
        push_exp(1'b1, 1'b0, 1'b0, 9'h0F1);
        push_dc(1'b0, 1'b1, 9'h0F1);
        drive_reqs();
        run(50);
        check("err_sticky", mem_err, 1'b1);

        // Reset two cycles into ACCESS aborts without a ready pulse
        ack_delay = 1000;
        seen0 = ready_seen;
        push_exp(1'b1, 1'b0, 1'b0, 9'h0AA);
        push_dc(1'b0, 1'b1, 9'h0AA);
        drive_reqs();
        tick();
        tick();
        check("pre_rst_strobe", mem_rd, 1'b1);
        reset = 1'b1;
        ic_pend.delete();
        dc_pend.delete();
        drive_reqs();
        tick();
        check("abort_mem_rd", mem_rd, 1'b0);
        check("abort_mem_wr", mem_wr, 1'b0);
        check("abort_err", mem_err, 1'b0);
        check("abort_ic_line", ic_line, '0);
        check("abort_dc_line", dc_line, '0);
        cur_valid = 1'b0;
        exp_q.delete();
        reset = 1'b0;
        tick();
        check("abort_no_ready", ready_seen - seen0, 0);

        // Back in IDLE: a fresh request completes with minimum latency
        ack_delay = 1;
        start = ncyc;
        push_exp(1'b0, 1'b0, 1'b0, 9'h0BB);
        ic_pend.push_back(9'h0BB);
        drive_reqs();
        run(50);
        check("post_rst_latency", ready_cyc - start, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
